// File: rtl/sap_apb_master_pkg.sv
// Shared definitions for the SAP APB4 requester: bus widths, FSM encoding and
// timeout counter sizing.
package sap_apb_master_pkg;

  localparam int unsigned APB_ADDR_WIDTH_DEF   = 32;
  localparam int unsigned APB_DATA_WIDTH_DEF   = 32;
  localparam int unsigned APB_STROBE_WIDTH_DEF = APB_DATA_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sap_apb_master_if.sv
// Command/response stream plus APB4 bus signals of the SAP APB requester.
// The master modport is the requester's view; slave is the environment's view.
interface sap_apb_master_if #(
  parameter int unsigned APB_ADDR_WIDTH   = sap_apb_master_pkg::APB_ADDR_WIDTH_DEF,
  parameter int unsigned APB_DATA_WIDTH   = sap_apb_master_pkg::APB_DATA_WIDTH_DEF,
  parameter int unsigned APB_STROBE_WIDTH = sap_apb_master_pkg::APB_STROBE_WIDTH_DEF
);

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [APB_ADDR_WIDTH-1:0]   cmd_addr;
  logic [APB_DATA_WIDTH-1:0]   cmd_wdata;
  logic [APB_STROBE_WIDTH-1:0] cmd_strb;
  logic [2:0]                  cmd_prot;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [APB_DATA_WIDTH-1:0]   rsp_rdata;
  logic                        rsp_err;
  logic                        rsp_timeout;

  logic [APB_ADDR_WIDTH-1:0]   PADDR;
  logic [APB_DATA_WIDTH-1:0]   PWDATA;
  logic [APB_STROBE_WIDTH-1:0] PSTRB;
  logic [2:0]                  PPROT;
  logic                        PSEL;
  logic                        PENABLE;
  logic                        PWRITE;
  logic                        PREADY;
  logic                        PSLVERR;
  logic [APB_DATA_WIDTH-1:0]   PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PWDATA, PSTRB, PPROT, PSEL, PENABLE, PWRITE,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PWDATA, PSTRB, PPROT, PSEL, PENABLE, PWRITE,
    output PREADY, PSLVERR, PRDATA
  );

endinterface

// File: rtl/sap_apb_master_timeout_cnt.sv
// Saturating ACCESS-cycle counter; expired flags the last permitted wait cycle.
module apb_timeout_cnt
  import sap_apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/sap_apb_master.sv
// APB4 requester: one valid/ready command becomes one APB transfer and one
// registered response, with a PREADY timeout guarding against stalled slaves.
module sap_apb_master
  import sap_apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH   = APB_ADDR_WIDTH_DEF,
  parameter int unsigned APB_DATA_WIDTH   = APB_DATA_WIDTH_DEF,
  parameter int unsigned APB_STROBE_WIDTH = APB_STROBE_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  sap_apb_master_if.master  bus
);

  apb_state_e                  state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [APB_STROBE_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [2:0]                  pprot_q, pprot_d;
  logic                        pwrite_q, pwrite_d;
  logic                        psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_err_q, rsp_err_d;
  logic                        rsp_timeout_q, rsp_timeout_d;

  logic cmd_ready;
  logic cmd_hs;
  logic expired;

  // PRESET gates cmd_ready directly so the handshake is closed during reset.
  assign cmd_ready = (state_q == IDLE) & ~rsp_valid_q & ~PRESET;
  assign cmd_hs    = cmd_ready & bus.cmd_valid;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clear_i  (cmd_hs),
    .enable_i (state_q == ACCESS),
    .expired_o(expired)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pprot_d   = bus.cmd_prot;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // Completion takes priority over a coincident terminal count.
        if (bus.PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else if (expired) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PPROT       = pprot_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;

endmodule
